// File: rtl/hack_decode_stage.sv
// Registered Hack instruction decode stage with a two-entry skid buffer,
// illegal-encoding NOP substitution, flush, and a saturating illegal counter.
module hack_decode_stage #(
    parameter int DW     = 16,
    parameter bit STRICT = 1'b1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_is_c,
    output logic [DW-1:0]    out_imm,
    output logic [5:0]       out_alu,
    output logic             out_sel_m,
    output logic             out_load_a,
    output logic             out_load_d,
    output logic             out_write_m,
    output logic [2:0]       out_jmp,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        logic          is_c;
        logic [DW-1:0] imm;
        logic [5:0]    alu;
        logic          sel_m;
        logic          load_a;
        logic          load_d;
        logic          write_m;
        logic [2:0]    jmp;
        logic          illegal;
    } bundle_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic comp_legal(input logic a, input logic [5:0] c);
        logic ok;
        ok = 1'b0;
        case (c)
            6'b110000, 6'b110001, 6'b110011, 6'b110111, 6'b110010,
            6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101: ok = 1'b1;
            6'b101010, 6'b111111, 6'b111010, 6'b001100,
            6'b001101, 6'b001111, 6'b011111, 6'b001110:             ok = !a;
            default:                                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Illegal C-instructions collapse to the "0" computation with no side effects.
    function automatic bundle_t decode(input logic [15:0] i);
        bundle_t b;
        b = '0;
        if (!i[15]) begin
            b.load_a = 1'b1;
            b.imm    = DW'(i[14:0]);
        end else begin
            b.is_c = 1'b1;
            if (!comp_legal(i[12], i[11:6]) || (STRICT && i[14:13] != 2'b11)) begin
                b.alu     = 6'b101010;
                b.illegal = 1'b1;
            end else begin
                b.alu     = i[11:6];
                b.sel_m   = i[12];
                b.load_a  = i[5];
                b.load_d  = i[4];
                b.write_m = i[3];
                b.jmp     = i[2:0];
            end
        end
        return b;
    endfunction

    bundle_t main_q, skid_q, dec, shown;
    logic    main_valid, skid_valid, ready_en;
    logic    accept, pop;

    assign dec      = decode(in_instr);
    assign in_ready = ready_en && !skid_valid && !flush;
    assign accept   = in_valid && in_ready;
    assign pop      = main_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid  <= 1'b0;
            skid_valid  <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
            ready_en    <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (pop) begin
                if (skid_valid) begin
                    main_q     <= skid_q;
                    skid_valid <= 1'b0;
                end else begin
                    main_valid <= accept;
                    if (accept) main_q <= dec;
                end
            end else if (accept) begin
                if (main_valid) begin
                    skid_q     <= dec;
                    skid_valid <= 1'b1;
                end else begin
                    main_q     <= dec;
                    main_valid <= 1'b1;
                end
            end
            if (accept && dec.illegal && illegal_cnt != CNT_MAX)
                illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

    // Outputs read as zero whenever no bundle is held.
    assign shown       = main_valid ? main_q : '0;
    assign out_valid   = main_valid;
    assign out_is_c    = shown.is_c;
    assign out_imm     = shown.imm;
    assign out_alu     = shown.alu;
    assign out_sel_m   = shown.sel_m;
    assign out_load_a  = shown.load_a;
    assign out_load_d  = shown.load_d;
    assign out_write_m = shown.write_m;
    assign out_jmp     = shown.jmp;
    assign out_illegal = shown.illegal;

endmodule
